// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply job sequencer: state encodings
// and the RAM header layout.
package mm_pkg;

    localparam logic [2:0] SEQ_IDLE     = 3'd0;
    localparam logic [2:0] SEQ_SWITCH   = 3'd1;
    localparam logic [2:0] SEQ_START    = 3'd2;
    localparam logic [2:0] SEQ_RUN      = 3'd3;
    localparam logic [2:0] SEQ_COMPLETE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = SEQ_IDLE,
        ST_SWITCH   = SEQ_SWITCH,
        ST_START    = SEQ_START,
        ST_RUN      = SEQ_RUN,
        ST_COMPLETE = SEQ_COMPLETE
    } seq_state_e;

    localparam int unsigned HDR_ADDR  = 32'd0;
    localparam int unsigned META_ADDR = 32'd1;
    localparam int unsigned DATA_BASE = 32'd2;

endpackage

// File: rtl/mm_ram_mux.sv
// Combinational owner select for the shared data RAM, with overrides that
// suppress writes and pin the address while ownership is changing hands.
module mm_ram_mux #(
    parameter int data_w = 32,
    parameter int add_w  = 9
) (
    input  logic              sel_cu,
    input  logic              force_we_off,
    input  logic              force_addr_en,
    input  logic [add_w-1:0]  force_addr,
    input  logic              host_we,
    input  logic [add_w-1:0]  host_addr,
    input  logic [data_w-1:0] host_wdata,
    input  logic              cu_we,
    input  logic [add_w-1:0]  cu_addr,
    input  logic [data_w-1:0] cu_wdata,
    output logic              ram_we,
    output logic [add_w-1:0]  ram_addr,
    output logic [data_w-1:0] ram_wdata
);

    logic              we_s;
    logic [add_w-1:0]  addr_s;
    logic [data_w-1:0] wdata_s;

    // Pick the current owner of the RAM port.
    always_comb begin
        if (sel_cu) begin
            we_s    = cu_we;
            addr_s  = cu_addr;
            wdata_s = cu_wdata;
        end else begin
            we_s    = host_we;
            addr_s  = host_addr;
            wdata_s = host_wdata;
        end
    end

    assign ram_we    = force_we_off  ? 1'b0 : we_s;
    assign ram_addr  = force_addr_en ? force_addr : addr_s;
    assign ram_wdata = wdata_s;

endmodule

// File: rtl/mm_job_sequencer.sv
// Job-level controller in front of the 2x2-block matmul CU: RAM time-sharing,
// CU start/completion handling and run-cycle measurement. Watchdog: MM_SEQ_TIMEOUT_EN.
module mm_job_sequencer
    import mm_pkg::*;
#(
    parameter int                data_w         = 32,
    parameter int                ram_d          = 512,
    parameter int                ram_add_w      = $clog2(ram_d),
    parameter int                cnt_w          = 24,
    parameter logic [cnt_w-1:0]  timeout_cycles = 24'd1000000,
    parameter int                blank_cycles   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_start,
    input  logic                 host_we,
    input  logic [ram_add_w-1:0] host_addr,
    input  logic [data_w-1:0]    host_wdata,
    output logic [data_w-1:0]    host_rdata,
    output logic                 host_grant,
    output logic                 cu_start,
    output logic                 cu_abort,
    input  logic                 cu_done,
    input  logic                 cu_err,
    input  logic                 cu_ram_we,
    input  logic [ram_add_w-1:0] cu_ram_addr,
    input  logic [data_w-1:0]    cu_ram_w_data,
    output logic                 ram_we,
    output logic [ram_add_w-1:0] ram_addr,
    output logic [data_w-1:0]    ram_w_data,
    input  logic [data_w-1:0]    ram_r_data,
    output logic                 busy,
    output logic                 job_done,
    output logic                 job_err,
    output logic                 job_timeout,
    output logic [cnt_w-1:0]     run_cycles
);

    localparam int blank_w = $clog2(blank_cycles + 1);

    seq_state_e         state_q, state_d;
    logic               host_grant_q, host_grant_d;
    logic               cu_start_q, cu_start_d;
    logic               cu_abort_q, cu_abort_d;
    logic               busy_q, busy_d;
    logic               job_done_q, job_done_d;
    logic               job_err_q, job_err_d;
    logic               job_timeout_q, job_timeout_d;
    logic [cnt_w-1:0]   run_cycles_q, run_cycles_d;
    logic [blank_w-1:0] blank_q, blank_d;
    logic [cnt_w-1:0]   run_inc_s;
    logic               status_live_s;

`ifndef MM_SEQ_TIMEOUT_EN
    logic               unused_timeout_s;
    assign unused_timeout_s = ^timeout_cycles;
`endif

    assign run_inc_s     = (run_cycles_q == {cnt_w{1'b1}}) ? run_cycles_q : run_cycles_q + cnt_w'(1);
    assign status_live_s = (blank_q == '0);

    // Next-state and registered-output computation for the job FSM.
    always_comb begin
        state_d       = state_q;
        host_grant_d  = host_grant_q;
        cu_start_d    = 1'b0;
        cu_abort_d    = 1'b0;
        busy_d        = busy_q;
        job_done_d    = job_done_q;
        job_err_d     = job_err_q;
        job_timeout_d = job_timeout_q;
        run_cycles_d  = run_cycles_q;
        blank_d       = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (job_start) begin
                    state_d       = ST_SWITCH;
                    host_grant_d  = 1'b0;
                    busy_d        = 1'b1;
                    job_done_d    = 1'b0;
                    job_err_d     = 1'b0;
                    job_timeout_d = 1'b0;
                    run_cycles_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                state_d    = ST_START;
                cu_start_d = 1'b1;
            end
            ST_START: begin
                state_d = ST_RUN;
                blank_d = blank_w'(blank_cycles);
            end
            ST_RUN: begin
                run_cycles_d = run_inc_s;
                // CU status is stale right after start; hold it off until blanking expires.
                if (!status_live_s) begin
                    blank_d = blank_q - blank_w'(1);
                end else begin
                    blank_d = blank_q;
                end
                if (status_live_s && cu_err) begin
                    job_err_d = 1'b1;
                    state_d   = ST_COMPLETE;
                end else if (status_live_s && cu_done) begin
                    job_done_d = 1'b1;
                    state_d    = ST_COMPLETE;
`ifdef MM_SEQ_TIMEOUT_EN
                end else if (run_inc_s == timeout_cycles) begin
                    job_timeout_d = 1'b1;
                    job_err_d     = 1'b1;
                    cu_abort_d    = 1'b1;
                    state_d       = ST_COMPLETE;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_COMPLETE: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                host_grant_d = 1'b1;
            end
            default: begin
                state_d      = ST_IDLE;
                host_grant_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            host_grant_q  <= 1'b1;
            cu_start_q    <= 1'b0;
            cu_abort_q    <= 1'b0;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            job_err_q     <= 1'b0;
            job_timeout_q <= 1'b0;
            run_cycles_q  <= '0;
            blank_q       <= '0;
        end else begin
            state_q       <= state_d;
            host_grant_q  <= host_grant_d;
            cu_start_q    <= cu_start_d;
            cu_abort_q    <= cu_abort_d;
            busy_q        <= busy_d;
            job_done_q    <= job_done_d;
            job_err_q     <= job_err_d;
            job_timeout_q <= job_timeout_d;
            run_cycles_q  <= run_cycles_d;
            blank_q       <= blank_d;
        end
    end

    mm_ram_mux #(
        .data_w (data_w),
        .add_w  (ram_add_w)
    ) u_ram_mux (
        .sel_cu        ((state_q == ST_START) || (state_q == ST_RUN)),
        .force_we_off  ((state_q == ST_SWITCH) || (state_q == ST_COMPLETE)),
        .force_addr_en ((state_q == ST_SWITCH) || (state_q == ST_COMPLETE)),
        .force_addr    (ram_add_w'(HDR_ADDR)),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .cu_we         (cu_ram_we),
        .cu_addr       (cu_ram_addr),
        .cu_wdata      (cu_ram_w_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_w_data)
    );

    assign host_rdata  = ram_r_data;
    assign host_grant  = host_grant_q;
    assign cu_start    = cu_start_q;
    assign cu_abort    = cu_abort_q;
    assign busy        = busy_q;
    assign job_done    = job_done_q;
    assign job_err     = job_err_q;
    assign job_timeout = job_timeout_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Randomized self-checking bench for mm_job_sequencer with a RAM model and a
// job-level reference model of CU handshake outcomes.
module tb_mm_job_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int CW    = 24;
    localparam int BLANK = 3;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_start;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_grant;
    logic          cu_start;
    logic          cu_abort;
    logic          cu_done;
    logic          cu_err;
    logic          cu_ram_we;
    logic [AW-1:0] cu_ram_addr;
    logic [DW-1:0] cu_ram_w_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data;
    logic          busy;
    logic          job_done;
    logic          job_err;
    logic          job_timeout;
    logic [CW-1:0] run_cycles;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem     [0:511];
    logic [DW-1:0] exp_mem [0:511];

    always #5 clk = ~clk;

    mm_job_sequencer #(
        .data_w(DW), .ram_d(512), .ram_add_w(AW), .cnt_w(CW),
        .timeout_cycles(24'd100), .blank_cycles(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .job_start(job_start),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_grant(host_grant),
        .cu_start(cu_start), .cu_abort(cu_abort), .cu_done(cu_done), .cu_err(cu_err),
        .cu_ram_we(cu_ram_we), .cu_ram_addr(cu_ram_addr), .cu_ram_w_data(cu_ram_w_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .busy(busy), .job_done(job_done), .job_err(job_err), .job_timeout(job_timeout),
        .run_cycles(run_cycles)
    );

    // Single-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_w_data;
        ram_r_data <= mem[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CU error line as seen in RUN cycle r: stale error for the first stale_n cycles,
    // then a real error from err_at onward (0 = never).
    function automatic bit err_seen(input int r, input int err_at, input int stale_n);
        return (r <= stale_n) || (err_at != 0 && r >= err_at);
    endfunction

    // RUN cycle in which the job ends: first cycle past the blanking window
    // in which the CU reports anything.
    function automatic int end_cycle(input int done_at, input int err_at, input int stale_n);
        for (int r = 1; r < 1000; r++) begin
            if (r > BLANK && (err_seen(r, err_at, stale_n) || (done_at != 0 && r >= done_at)))
                return r;
        end
        return 0;
    endfunction

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tests++;
        if (host_grant !== 1'b1) begin
            fails++;
            $display("FAIL host_write_grant: got %0b want 1", host_grant);
        end
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic host_read_check(input logic [AW-1:0] a, input string name);
        host_we = 1'b0; host_addr = a;
        tick();
        tests++;
        if (host_rdata !== exp_mem[a]) begin
            fails++;
            $display("FAIL %s: addr %0d got %h want %h", name, a, host_rdata, exp_mem[a]);
        end
    endtask

    // Raise job_start and follow the sequencer through SWITCH into START.
    task automatic start_job(input string name);
        job_start = 1'b1;
        host_we = 1'b1; host_addr = 9'd7; host_wdata = 32'hDEAD_BEEF;
        tick();
        job_start = 1'b0;
        #1;
        tests++;
        if (host_grant !== 1'b0 || busy !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'd0 || cu_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_switch: grant=%0b busy=%0b ram_we=%0b ram_addr=%0d cu_start=%0b want 0 1 0 0 0",
                     name, host_grant, busy, ram_we, ram_addr, cu_start);
        end
        tests++;
        if (job_done !== 1'b0 || job_err !== 1'b0 || job_timeout !== 1'b0 || run_cycles !== '0) begin
            fails++;
            $display("FAIL %s_clear: done=%0b err=%0b tmo=%0b run=%0d want all 0",
                     name, job_done, job_err, job_timeout, run_cycles);
        end
        host_we = 1'b0;
        tick();
        tests++;
        if (cu_start !== 1'b1) begin
            fails++;
            $display("FAIL %s_cu_start: got %0b want 1 two cycles after job_start", name, cu_start);
        end
    endtask

    task automatic run_job(input int done_at, input int err_at, input int stale_n, input bit poke, input string name);
        int  rc;
        bit  want_err;
        rc = end_cycle(done_at, err_at, stale_n);
        want_err = err_seen(rc, err_at, stale_n);
        start_job(name);
        for (int r = 1; r <= rc; r++) begin
            tick();
            cu_done       = (done_at != 0 && r >= done_at);
            cu_err        = err_seen(r, err_at, stale_n);
            cu_ram_we     = 1'($urandom_range(0, 1));
            cu_ram_addr   = 9'd100 + 9'($urandom_range(0, 99));
            cu_ram_w_data = $urandom;
            if (poke) begin
                host_we = 1'b1; host_addr = 9'd5; host_wdata = $urandom;
            end else begin
                host_we = 1'b0;
            end
            #1;
            tests++;
            if (ram_we !== cu_ram_we || (cu_ram_we && (ram_addr !== cu_ram_addr || ram_w_data !== cu_ram_w_data))) begin
                fails++;
                $display("FAIL %s_mux r=%0d: we=%0b addr=%0d data=%h want %0b %0d %h",
                         name, r, ram_we, ram_addr, ram_w_data, cu_ram_we, cu_ram_addr, cu_ram_w_data);
            end
            tests++;
            if (busy !== 1'b1 || host_grant !== 1'b0 || run_cycles !== CW'(r - 1) || cu_abort !== 1'b0 ||
                (r == 1 && cu_start !== 1'b0)) begin
                fails++;
                $display("FAIL %s_run r=%0d: busy=%0b grant=%0b run=%0d abort=%0b start=%0b want 1 0 %0d 0 0",
                         name, r, busy, host_grant, run_cycles, cu_abort, cu_start, r - 1);
            end
            if (cu_ram_we) exp_mem[cu_ram_addr] = cu_ram_w_data;
        end
        tick();
        cu_done = 1'b0; cu_err = 1'b0; cu_ram_we = 1'b0; host_we = 1'b0;
        #1;
        tests++;
        if (job_err !== want_err || job_done !== !want_err || run_cycles !== CW'(rc) || job_timeout !== 1'b0) begin
            fails++;
            $display("FAIL %s_result: done=%0b err=%0b tmo=%0b run=%0d want %0b %0b 0 %0d",
                     name, job_done, job_err, job_timeout, run_cycles, !want_err, want_err, rc);
        end
        tests++;
        if (busy !== 1'b1 || host_grant !== 1'b0 || ram_we !== 1'b0) begin
            fails++;
            $display("FAIL %s_complete: busy=%0b grant=%0b ram_we=%0b want 1 0 0", name, busy, host_grant, ram_we);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || host_grant !== 1'b1) begin
            fails++;
            $display("FAIL %s_idle: busy=%0b grant=%0b want 0 1", name, busy, host_grant);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++;
        if (host_grant !== 1'b1 || busy !== 1'b0 || cu_start !== 1'b0 || cu_abort !== 1'b0 ||
            job_done !== 1'b0 || job_err !== 1'b0 || job_timeout !== 1'b0 || run_cycles !== '0) begin
            fails++;
            $display("FAIL reset: grant=%0b busy=%0b start=%0b abort=%0b done=%0b err=%0b tmo=%0b run=%0d want 1 0 0 0 0 0 0 0",
                     host_grant, busy, cu_start, cu_abort, job_done, job_err, job_timeout, run_cycles);
        end
        host_we = 1'b1; host_addr = 9'd3; host_wdata = 32'h1234_5678;
        #1;
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 9'd3 || ram_w_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL idle_mux: we=%0b addr=%0d data=%h want 1 3 12345678", ram_we, ram_addr, ram_w_data);
        end
        tick();
        host_we = 1'b0;
        exp_mem[3] = 32'h1234_5678;
        host_read_check(9'd3, "idle_readback");
    endtask

    task automatic test_basic();
        host_write(9'd0, 32'h0202_0202);
        host_read_check(9'd0, "header_readback");
        run_job(40, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_stale_err();
        run_job(int'($urandom_range(5, 60)), 0, 2, 1'b0, "stale_err");
        run_job(1, 0, 0, 1'b0, "done_in_blank");
    endtask

    task automatic test_err_and_done();
        run_job(10, 10, 0, 1'b0, "err_wins");
    endtask

    task automatic test_host_drop();
        host_write(9'd5, 32'hA5A5_0005);
        run_job(int'($urandom_range(8, 30)), 0, 0, 1'b1, "host_drop");
        host_read_check(9'd5, "addr5_kept");
        for (int a = 100; a < 200; a += 33) host_read_check(9'(a), "cu_write");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int d, e, s;
            d = int'($urandom_range(1, 60));
            e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
            s = int'($urandom_range(0, 3));
            run_job(d, e, s, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_restart_and_reset();
        int starts = 0;
        start_job("restart");
        for (int r = 1; r <= 20; r++) begin
            tick();
            job_start = (r == 5);
            #1;
            if (cu_start === 1'b1) starts++;
        end
        job_start = 1'b0;
        tests++;
        if (starts != 0 || run_cycles !== CW'(19) || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_ignored: starts=%0d run=%0d busy=%0b want 0 19 1", starts, run_cycles, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || host_grant !== 1'b1 || job_done !== 1'b0 || job_err !== 1'b0 ||
            job_timeout !== 1'b0 || run_cycles !== '0 || cu_start !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: busy=%0b grant=%0b done=%0b err=%0b tmo=%0b run=%0d start=%0b want 0 1 0 0 0 0 0",
                     busy, host_grant, job_done, job_err, job_timeout, run_cycles, cu_start);
        end
    endtask

`ifdef MM_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int aborts = 0;
        int abort_run = -1;
        bit flags_ok = 1'b0;
        bit busy_next = 1'b1;
        bit seen = 1'b0;
        start_job("timeout");
        for (int r = 1; r <= 150; r++) begin
            tick();
            #1;
            if (seen && abort_run >= 0 && aborts == 1 && r == 0) busy_next = busy;
            if (cu_abort === 1'b1) begin
                aborts++;
                abort_run = int'(run_cycles);
                flags_ok = (job_timeout === 1'b1) && (job_err === 1'b1) && (job_done === 1'b0) && (busy === 1'b1);
                tick();
                #1;
                busy_next = busy;
                if (cu_abort === 1'b1) aborts++;
                seen = 1'b1;
            end
        end
        tests++;
        if (aborts != 1 || abort_run != TMO) begin
            fails++;
            $display("FAIL timeout_abort: pulses=%0d at run=%0d want 1 at %0d", aborts, abort_run, TMO);
        end
        tests++;
        if (!flags_ok || busy_next !== 1'b0) begin
            fails++;
            $display("FAIL timeout_flags: flags_ok=%0b busy_after=%0b want 1 0", flags_ok, busy_next);
        end
    endtask
`else
    task automatic test_long_wait();
        run_job(150, 0, 0, 1'b0, "long_wait");
    endtask
`endif

    initial begin
        rst = 1'b1; job_start = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        cu_done = 1'b0; cu_err = 1'b0;
        cu_ram_we = 1'b0; cu_ram_addr = '0; cu_ram_w_data = '0;
        test_reset();
        test_basic();
        test_stale_err();
        test_err_and_done();
        test_host_drop();
        test_random();
`ifdef MM_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_restart_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
